// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester memory arbiter (fetch + data) in front of a
// single memory port with an ack handshake and a per-access timeout.
//
// Parameters:
//   TIMEOUT   maximum cycles to wait for m_ack before aborting (2..255)
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   if_req/if_addr        fetch request in; if_rdata/if_ready response out
//   d_req/d_we/d_addr/    data request in
//   d_wdata
//   d_rdata/d_ready       data response out
//   m_req/m_we/m_addr/    memory request out
//   m_wdata
//   m_rdata/m_ack         memory response in
//   stall                 combinational pipeline hold
//   err                   timeout flag, high during the aborted access's ready
//
// Configuration macro:
//   MEM_ARBITER_FAIR_EN   after two consecutive data grants made while fetch
//                         was waiting, the next grant goes to fetch.
//                         Undefined: data has strict priority.

module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       grant_d;
  logic       grant_i;

`ifdef MEM_ARBITER_FAIR_EN
  logic [1:0] fair_cnt;

  // Once data has won twice in a row while fetch was waiting, fetch gets
  // the next grant; otherwise data keeps priority.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (fair_cnt == 2'd2 && if_req) begin
      grant_i = 1'b1;
    end else if (d_req) begin
      grant_d = 1'b1;
    end else if (if_req) begin
      grant_i = 1'b1;
    end
  end

  // A data grant with no fetch waiting breaks the run of consecutive
  // "unfair" grants, so the count restarts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fair_cnt <= 2'd0;
    end else if (state == IDLE) begin
      if (grant_i) begin
        fair_cnt <= 2'd0;
      end else if (grant_d) begin
        if (!if_req) begin
          fair_cnt <= 2'd0;
        end else if (fair_cnt != 2'd2) begin
          fair_cnt <= fair_cnt + 2'd1;
        end
      end
    end
  end
`else
  // Data always wins a tie.
  always_comb begin
    grant_d = d_req;
    grant_i = if_req & ~d_req;
  end
`endif

  // Main FSM. All outputs are registered here; ready/err pulses are set on
  // the edge entering RESP so they coincide with the RESP cycle. Request
  // fields are latched straight into the m_* registers at grant time and
  // held until the access ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'd0;
      m_wdata  <= 32'd0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (grant_d) begin
            state   <= DACC;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (grant_i) begin
            state   <= IACC;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= if_addr;
            m_wdata <= 32'd0;
          end
        end
        DACC, IACC: begin
          if (m_ack) begin
            state <= RESP;
            m_req <= 1'b0;
            if (state == DACC) begin
              d_ready <= 1'b1;
              if (!m_we) begin
                d_rdata <= m_rdata;
              end
            end else begin
              if_ready <= 1'b1;
              if_rdata <= m_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state <= RESP;
            m_req <= 1'b0;
            err   <= 1'b1;
            if (state == DACC) begin
              d_ready <= 1'b1;
              d_rdata <= ERR_DATA;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= ERR_DATA;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall = (d_req & ~d_ready) | (if_req & ~if_ready);

endmodule
